ras_ckpt: RTL and testbench

RAS_CKPT -- requirements
Module: ras_ckpt

---
 rtl/ariane_pkg.sv | 13 +
 rtl/ras_ckpt.sv | 117 +++++++++++
 tb/tb_ras_ckpt.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/ariane_pkg.sv
// Shared CVA6 types and user-config defaults used by the branch-prediction blocks.
package ariane_pkg;

  // CVA6 user config field; instantiation sites pass it to ras_ckpt's DEPTH.
  localparam int unsigned RASDepth = 2;
  localparam int unsigned RAS_VLEN = 32;

  typedef struct packed {
    logic                valid;
    logic [RAS_VLEN-1:0] ra;
  } ras_t;

endpackage

// File: rtl/ras_ckpt.sv
// Return-address stack with circular overwrite and an optional pointer checkpoint.
// Define RAS_CKPT_EN to build the {tos, count} snapshot used for mispredict recovery.
module ras_ckpt
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned VLEN  = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_bp_i,
  input  logic            push_i,
  input  logic [VLEN-1:0] data_i,
  input  logic            pop_i,
  input  logic            ckpt_i,
  input  logic            restore_i,
  output ras_t            data_o
);

  localparam int unsigned TW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [TW-1:0] TOS_LAST = TW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [VLEN-1:0] mem_q [DEPTH];
  logic [TW-1:0]   tos_q, tos_d, tos_op, tos_inc, tos_dec, wr_idx;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_op;
  logic            wr_op, wr_en;

  // Push/pop outcome before flush/restore priority is applied.
  always_comb begin
    tos_inc = (tos_q == TOS_LAST) ? '0 : tos_q + TW'(1);
    tos_dec = (tos_q == '0) ? TOS_LAST : tos_q - TW'(1);
    tos_op  = tos_q;
    cnt_op  = cnt_q;
    wr_op   = 1'b0;
    wr_idx  = tos_q;
    if (push_i && pop_i) begin
      wr_op = 1'b1;
      if (cnt_q == '0) cnt_op = CW'(1);
    end else if (push_i) begin
      tos_op = tos_inc;
      wr_op  = 1'b1;
      wr_idx = tos_inc;
      if (cnt_q != CNT_FULL) cnt_op = cnt_q + CW'(1);
    end else if (pop_i && (cnt_q != '0)) begin
      tos_op = tos_dec;
      cnt_op = cnt_q - CW'(1);
    end
  end

`ifdef RAS_CKPT_EN
  logic [TW-1:0] snap_tos_q;
  logic [CW-1:0] snap_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      snap_tos_q <= '0;
      snap_cnt_q <= '0;
    end else if (flush_bp_i) begin
      snap_tos_q <= '0;
      snap_cnt_q <= '0;
    end else if (!restore_i && ckpt_i) begin
      snap_tos_q <= tos_op;
      snap_cnt_q <= cnt_op;
    end
  end

  always_comb begin
    tos_d = tos_op;
    cnt_d = cnt_op;
    wr_en = wr_op && !flush_bp_i && !restore_i;
    if (flush_bp_i) begin
      tos_d = '0;
      cnt_d = '0;
    end else if (restore_i) begin
      tos_d = snap_tos_q;
      cnt_d = snap_cnt_q;
    end
  end
`else
  logic unused_ckpt;
  assign unused_ckpt = ckpt_i ^ restore_i;

  always_comb begin
    tos_d = tos_op;
    cnt_d = cnt_op;
    wr_en = wr_op && !flush_bp_i;
    if (flush_bp_i) begin
      tos_d = '0;
      cnt_d = '0;
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tos_q <= '0;
      cnt_q <= '0;
    end else begin
      tos_q <= tos_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_idx] <= data_i;
    end
  end

  assign data_o.valid = (cnt_q != '0);
  assign data_o.ra    = mem_q[tos_q];

endmodule

// File: tb/tb_ras_ckpt.sv
// Self-checking bench for ras_ckpt (DEPTH=4, VLEN=32): directed scenarios plus random traffic.
module tb_ras_ckpt;
  import ariane_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned VLEN  = 32;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            flush_bp_i, push_i, pop_i, ckpt_i, restore_i;
  logic [VLEN-1:0] data_i;
  ras_t            data_o;

  always #5 clk_i = ~clk_i;

  ras_ckpt #(.DEPTH(DEPTH), .VLEN(VLEN)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_bp_i (flush_bp_i),
    .push_i     (push_i),
    .data_i     (data_i),
    .pop_i      (pop_i),
    .ckpt_i     (ckpt_i),
    .restore_i  (restore_i),
    .data_o     (data_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference: stack as an array indexed by a modular top pointer plus a fill count.
  logic [VLEN-1:0] m_mem [DEPTH];
  int m_tos, m_cnt, m_snap_tos, m_snap_cnt;

  task automatic check_word(string tag, ras_t exp);
    n_checks++;
    assert (data_o === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h required %h", tag, data_o, exp);
    end
  endtask

  task automatic check_valid(string tag, logic exp);
    n_checks++;
    assert (data_o.valid === exp) else begin
      n_errors++;
      $error("FAIL %s: observed valid %b required %b", tag, data_o.valid, exp);
    end
  endtask

  task automatic check_ra(string tag, logic [VLEN-1:0] exp);
    n_checks++;
    assert (data_o === ras_t'({1'b1, exp})) else begin
      n_errors++;
      $error("FAIL %s: observed %h required valid ra %h", tag, data_o, exp);
    end
  endtask

  task automatic check_model(string tag);
    if (m_cnt != 0) check_ra(tag, m_mem[m_tos]);
    else            check_valid(tag, 1'b0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_tos = 0; m_cnt = 0; m_snap_tos = 0; m_snap_cnt = 0;
  endtask

  task automatic model_step(bit push, bit pop, bit ckpt, bit restore, bit flush,
                            logic [VLEN-1:0] d);
    if (flush) begin
      m_tos = 0; m_cnt = 0; m_snap_tos = 0; m_snap_cnt = 0;
    end
`ifdef RAS_CKPT_EN
    else if (restore) begin
      m_tos = m_snap_tos; m_cnt = m_snap_cnt;
    end
`endif
    else begin
      if (push && pop) begin
        m_mem[m_tos] = d;
        if (m_cnt == 0) m_cnt = 1;
      end else if (push) begin
        m_tos = (m_tos + 1) % DEPTH;
        m_mem[m_tos] = d;
        m_cnt = (m_cnt + 1 > DEPTH) ? DEPTH : m_cnt + 1;
      end else if (pop && m_cnt > 0) begin
        m_tos = (m_tos + DEPTH - 1) % DEPTH;
        m_cnt = m_cnt - 1;
      end
`ifdef RAS_CKPT_EN
      if (ckpt) begin
        m_snap_tos = m_tos; m_snap_cnt = m_cnt;
      end
`endif
    end
  endtask

  task automatic idle_inputs();
    push_i = 1'b0; pop_i = 1'b0; ckpt_i = 1'b0; restore_i = 1'b0; flush_bp_i = 1'b0;
    data_i = '0;
  endtask

  task automatic step(string tag, bit push, bit pop, bit ckpt, bit restore, bit flush,
                      logic [VLEN-1:0] d);
    @(negedge clk_i);
    push_i = push; pop_i = pop; ckpt_i = ckpt; restore_i = restore; flush_bp_i = flush;
    data_i = d;
    @(posedge clk_i);
    #1;
    model_step(push, pop, ckpt, restore, flush, d);
    check_model(tag);
    idle_inputs();
  endtask

  localparam logic [VLEN-1:0] VA = 32'hA000_00A1;
  localparam logic [VLEN-1:0] VB = 32'hB000_00B2;
  localparam logic [VLEN-1:0] VC = 32'hC000_00C3;
  localparam logic [VLEN-1:0] VD = 32'hD000_00D4;
  localparam logic [VLEN-1:0] VX = 32'h1234_5678;

  initial begin
    rst_ni = 1'b0;
    idle_inputs();
    model_reset();
    push_i = 1'b1; data_i = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk_i);
    #1 check_word("reset_hold", '0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    idle_inputs();
    @(posedge clk_i);
    #1 check_word("post_reset", '0);

    // Push three, pop three
    step("t32_push_a", 1, 0, 0, 0, 0, VA);
    step("t32_push_b", 1, 0, 0, 0, 0, VB);
    step("t32_push_c", 1, 0, 0, 0, 0, VC);
    check_ra("t32_top_c", VC);
    step("t32_pop1", 0, 1, 0, 0, 0, '0);
    check_ra("t32_top_b", VB);
    step("t32_pop2", 0, 1, 0, 0, 0, '0);
    check_ra("t32_top_a", VA);
    step("t32_pop3", 0, 1, 0, 0, 0, '0);
    check_valid("t32_empty", 1'b0);

    // Overflow wraps and drops the oldest entry
    for (int i = 1; i <= 5; i++) step("t33_push", 1, 0, 0, 0, 0, VLEN'(i));
    check_ra("t33_top5", 32'd5);
    step("t33_pop1", 0, 1, 0, 0, 0, '0);
    check_ra("t33_top4", 32'd4);
    step("t33_pop2", 0, 1, 0, 0, 0, '0);
    check_ra("t33_top3", 32'd3);
    step("t33_pop3", 0, 1, 0, 0, 0, '0);
    check_ra("t33_top2", 32'd2);
    step("t33_pop4", 0, 1, 0, 0, 0, '0);
    check_valid("t33_empty", 1'b0);
    step("t33_pop_underflow", 0, 1, 0, 0, 0, '0);
    check_valid("t33_still_empty", 1'b0);
    step("t33_push_after", 1, 0, 0, 0, 0, VD);

    // Simultaneous push and pop
    step("t34_flush", 0, 0, 0, 0, 1, '0);
    step("t34_push_a", 1, 0, 0, 0, 0, VA);
    step("t34_pushpop_b", 1, 1, 0, 0, 0, VB);
    check_ra("t34_top_b", VB);
    step("t34_pop", 0, 1, 0, 0, 0, '0);
    check_valid("t34_count1", 1'b0);
    step("t34_pushpop_x", 1, 1, 0, 0, 0, VX);
    check_ra("t34_top_x", VX);
    step("t34_pop_x", 0, 1, 0, 0, 0, '0);
    check_valid("t34_count1_x", 1'b0);

    // Checkpoint / restore
    step("t35_flush", 0, 0, 0, 0, 1, '0);
    step("t35_push_a", 1, 0, 0, 0, 0, VA);
    step("t35_ckpt", 0, 0, 1, 0, 0, '0);
    step("t35_push_b", 1, 0, 0, 0, 0, VB);
    step("t35_push_c", 1, 0, 0, 0, 0, VC);
    step("t35_restore", 0, 0, 0, 1, 0, '0);
`ifdef RAS_CKPT_EN
    check_ra("t35_restored_a", VA);
    step("t35_pop", 0, 1, 0, 0, 0, '0);
    check_valid("t35_count1", 1'b0);
`else
    check_ra("t35_no_ckpt_c", VC);
`endif

    // Flush beats everything, and clears the snapshot
    step("t36_push_a", 1, 0, 0, 0, 0, VA);
    step("t36_ckpt", 0, 0, 1, 0, 0, '0);
    step("t36_flush_all", 1, 1, 1, 1, 1, VD);
    check_valid("t36_flushed", 1'b0);
    step("t36_restore", 0, 0, 0, 1, 0, '0);
    check_valid("t36_snap_cleared", 1'b0);
    step("t36_push_d", 1, 0, 0, 0, 0, VD);

    // Asynchronous reset mid-push
    step("t37_push_a", 1, 0, 0, 0, 0, VA);
    @(negedge clk_i);
    push_i = 1'b1; data_i = VB;
    #2 rst_ni = 1'b0;
    #1 check_word("t37_async_clear", '0);
    model_reset();
    @(posedge clk_i);
    #1 check_word("t37_held", '0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    idle_inputs();
    step("t37_pop", 0, 1, 0, 0, 0, '0);
    check_word("t37_pop_zero", '0);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      int unsigned r;
      bit p, q, k, rs, f;
      r  = $urandom_range(0, 99);
      f  = (r < 3);
      rs = (r >= 3 && r < 9);
      k  = ($urandom_range(0, 4) == 0);
      p  = ($urandom_range(0, 9) < 5);
      q  = ($urandom_range(0, 9) < 4);
      step("rand", p, q, k, rs, f, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
